// File: rtl/dram_uart_tx_pkg.sv
// Shared definitions for the DRAM-to-UART result transmitter.
// Defining TX_PARITY_EN adds an even-parity bit and a PARITY state to every frame.
package dram_uart_tx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_BYTE_COUNT   = 16384;

    // Bit indices within a frame: 0 is the start bit, 1..8 carry data LSB first.
    localparam logic [3:0] LAST_DATA_BIT = 4'd8;

`ifdef TX_PARITY_EN
    localparam logic [3:0] STOP_BIT_INDEX = 4'd10;

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, START, DATA, PARITY, STOP, NEXT
    } tx_state_e;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`else
    localparam logic [3:0] STOP_BIT_INDEX = 4'd9;

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, START, DATA, STOP, NEXT
    } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: baud counter, shift register and bit counter behind a load/ready handshake.
// Honours TX_PARITY_EN by sending an even-parity bit ahead of the stop bit.
module uart_tx_serializer
    import dram_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       bit_tick,
    output logic [3:0] bit_index,
    output logic       tx
);

    localparam logic [15:0] LAST_BAUD = 16'(CLKS_PER_BIT - 1);

    logic [15:0] baud_cnt_r;
    logic [3:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic        active_r;
    logic        tx_r;
    logic        bit_end_s;
`ifdef TX_PARITY_EN
    logic        parity_r;
`endif

    assign bit_end_s = active_r && (baud_cnt_r == LAST_BAUD);
    assign ready     = ~active_r;
    assign bit_tick  = bit_end_s;
    assign bit_index = bit_cnt_r;
    assign tx        = tx_r;

    // Frame sequencing: tx always changes on a bit boundary so each bit lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'd0;
            active_r   <= 1'b0;
            tx_r       <= 1'b1;
`ifdef TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else if (load && !active_r) begin
            shift_r    <= data;
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 4'd0;
            active_r   <= 1'b1;
            tx_r       <= 1'b0;
`ifdef TX_PARITY_EN
            parity_r   <= even_parity(data);
`endif
        end else if (active_r) begin
            if (bit_end_s) begin
                baud_cnt_r <= 16'd0;
                if (bit_cnt_r == STOP_BIT_INDEX) begin
                    active_r  <= 1'b0;
                    bit_cnt_r <= 4'd0;
                    tx_r      <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                    if (bit_cnt_r < LAST_DATA_BIT) begin
                        tx_r    <= shift_r[0];
                        shift_r <= {1'b0, shift_r[7:1]};
`ifdef TX_PARITY_EN
                    end else if (bit_cnt_r == LAST_DATA_BIT) begin
                        tx_r <= parity_r;
`endif
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
            end else begin
                baud_cnt_r <= baud_cnt_r + 16'd1;
            end
        end
    end

endmodule

// File: rtl/dram_uart_tx.sv
// Streams BYTE_COUNT result bytes from DRAM address 0 upward out of a UART line.
// Defining TX_PARITY_EN adds an even-parity bit (PARITY state) to every frame.
module dram_uart_tx
    import dram_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int BYTE_COUNT   = DEFAULT_BYTE_COUNT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_Tx,
    output logic [15:0] DRAM_address_tx,
    input  logic [7:0]  DRAM_input_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    // 17 bits so that BYTE_COUNT = 65536 ends at 65535 instead of wrapping.
    localparam logic [16:0] LAST_INDEX = 17'(BYTE_COUNT - 1);

    tx_state_e   state_r;
    tx_state_e   state_next_s;
    logic [16:0] index_r;
    logic [16:0] index_next_s;
    logic        start_prev_r;
    logic        busy_r;
    logic        busy_next_s;
    logic        done_r;
    logic        done_next_s;
    logic        start_rise_s;
    logic        load_s;
    logic        ser_ready_s;
    logic        bit_tick_s;
    logic [3:0]  bit_index_s;

    assign start_rise_s    = start_Tx & ~start_prev_r;
    assign DRAM_address_tx = index_r[15:0];
    assign busy            = busy_r;
    assign done            = done_r;

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_serializer (
        .clock     (clock),
        .reset     (reset),
        .load      (load_s),
        .data      (DRAM_input_data),
        .ready     (ser_ready_s),
        .bit_tick  (bit_tick_s),
        .bit_index (bit_index_s),
        .tx        (tx)
    );

    // State, index and status registers; reset drops any frame in flight without a done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            index_r      <= 17'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            start_prev_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            index_r      <= index_next_s;
            busy_r       <= busy_next_s;
            done_r       <= done_next_s;
            start_prev_r <= start_Tx;
        end
    end

    // Next-state logic: DRAM data arrives in LATCH, one cycle after the address shown in FETCH.
    always_comb begin
        state_next_s = state_r;
        index_next_s = index_r;
        busy_next_s  = busy_r;
        done_next_s  = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_rise_s) begin
                    state_next_s = FETCH;
                    index_next_s = 17'd0;
                    busy_next_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                state_next_s = LATCH;
            end
            LATCH: begin
                if (ser_ready_s) begin
                    load_s       = 1'b1;
                    state_next_s = START;
                end else begin
                    state_next_s = LATCH;
                end
            end
            START: begin
                if (bit_tick_s) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_tick_s && (bit_index_s == LAST_DATA_BIT)) begin
`ifdef TX_PARITY_EN
                    state_next_s = PARITY;
`else
                    state_next_s = STOP;
`endif
                end else begin
                    state_next_s = DATA;
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (bit_tick_s) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (bit_tick_s) begin
                    state_next_s = NEXT;
                end else begin
                    state_next_s = STOP;
                end
            end
            NEXT: begin
                if (index_r == LAST_INDEX) begin
                    state_next_s = IDLE;
                    busy_next_s  = 1'b0;
                    done_next_s  = 1'b1;
                end else begin
                    state_next_s = FETCH;
                    index_next_s = index_r + 17'd1;
                end
            end
            default: begin
                state_next_s = IDLE;
                busy_next_s  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/dram_uart_tx.md
DRAM_UART_TX -- requirements
Module: dram_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter BYTE_COUNT, default 16384, number of result bytes read from DRAM address 0 upward; legal range 1..65536.
REQ-003 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start_Tx, input, 1, processor request to transmit the downsampled image.
REQ-006 SHALL have port DRAM_address_tx, output, 16, DRAM read address.
REQ-007 SHALL have port DRAM_input_data, input, 8, DRAM read data; valid exactly one cycle after the address is presented.
REQ-008 SHALL have port tx, output, 1, UART serial line; idle high.
REQ-009 SHALL have port busy, output, 1, high from transfer acceptance until the last stop bit ends.
REQ-010 SHALL have port done, output, 1, one-cycle pulse after the last byte's stop bit.

Function
REQ-011 SHALL implement the states IDLE, FETCH, LATCH, START, DATA, STOP, NEXT.
REQ-012 SHALL accept a transfer only in IDLE, and only on a start_Tx rising edge (0 in the previous cycle, 1 in the current one), then go to FETCH.
REQ-013 SHALL present the byte index on DRAM_address_tx in FETCH and capture DRAM_input_data into the shift register in LATCH, the following cycle.
REQ-014 SHALL transmit each byte as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), each bit held for exactly CLKS_PER_BIT cycles.
REQ-015 SHALL, in NEXT, go to IDLE and pulse done if the index equals BYTE_COUNT-1; otherwise it SHALL increment the index and return to FETCH.
REQ-016 SHALL use a 17-bit index so that BYTE_COUNT=65536 terminates at index 65535 without wrapping to 0; DRAM_address_tx carries index[15:0].
REQ-017 SHALL ignore start_Tx while busy; a start_Tx level held high through and after done SHALL NOT retrigger.
REQ-018 SHALL hold tx at 1 in IDLE, FETCH, LATCH and NEXT, giving 3 idle cycles between consecutive frames.
REQ-019 SHALL register tx so that it has no combinational path from any input.

Reset
REQ-020 SHALL, when reset is high at a clock edge, force state=IDLE, tx=1, busy=0, done=0, DRAM_address_tx=0, index=0, bit and baud counters=0, and the edge-detect register=0.
REQ-021 SHALL abort a frame on reset mid-frame: tx returns high on the next edge, and no done pulse is produced.
REQ-022 SHALL treat start_Tx held high across reset release as a new rising edge.

Configuration
REQ-023 SHALL, when TX_PARITY_EN is defined, insert an even-parity bit (XOR of the 8 data bits) of CLKS_PER_BIT cycles between the last data bit and the stop bit, using an added PARITY state.
REQ-024 SHALL, when TX_PARITY_EN is undefined, contain no parity logic, giving 10-bit frames.

Structure
REQ-025 SHALL take the state enumeration, DEFAULT_CLKS_PER_BIT and DEFAULT_BYTE_COUNT from the shared processor package.
REQ-026 SHALL instantiate one sub-module, uart_tx_serializer (baud counter, shift register, bit counter, load/ready handshake); dram_uart_tx itself SHALL hold the FSM, the index and the DRAM sequencing.

Verification (CLKS_PER_BIT=4, BYTE_COUNT=3, DRAM[0..2]=0x55,0xA3,0x00)
REQ-027 SHALL cover: single start_Tx pulse -> tx sequence 0,1,0,1,0,1,0,1,0,1 per 4-cycle bit for 0x55; addresses 0,1,2; done pulses once; busy falls in the same cycle.
REQ-028 SHALL cover: byte 0xA3 -> data bits 1,1,0,0,0,1,0,1; frame length 40 cycles, and 43 cycles start-bit to start-bit.
REQ-029 SHALL cover: start_Tx held high for 200 cycles -> exactly one transfer and one done pulse.
REQ-030 SHALL cover: reset asserted during byte 1 bit 4 -> tx=1, busy=0 the next cycle, no done; a new start_Tx restarts at address 0.
REQ-031 SHALL cover: TX_PARITY_EN defined -> parity bits 0 (0x55), 0 (0xA3), 0 (0x00); frame length 44 cycles.
REQ-032 SHALL cover: BYTE_COUNT=1, CLKS_PER_BIT=2 -> one 20-cycle frame, address stays 0, done pulses.
